// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// and the datapath mux/ALU select codes it drives.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTI  = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [2:0] ST_IF    = 3'b000;
  localparam logic [2:0] ST_ID    = 3'b001;
  localparam logic [2:0] ST_EXE   = 3'b010;
  localparam logic [2:0] ST_MEM   = 3'b011;
  localparam logic [2:0] ST_WB_AL = 3'b100;
  localparam logic [2:0] ST_WB_LD = 3'b101;
  localparam logic [2:0] ST_HALT  = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_REG    = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  localparam logic [1:0] REGDST_RA = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RD = 2'b10;

  typedef struct packed {
    logic isRtype;
    logic isImm;
    logic isLoad;
    logic isStore;
    logic isBranch;
    logic isJump;
    logic isHalt;
    logic isUndef;
  } opClass_t;

endpackage

// File: rtl/mc_ctrl_unit_if.sv
// Control-unit <-> datapath bundle: IR/ALU status in, enables and selects out.
interface mc_ctrl_unit_if;
  logic [5:0] opcode;
  logic       zero;
  logic       sign;
  logic [2:0] state;
  logic       PCWre;
  logic       IRWre;
  logic       InsMemRW;
  logic       RegWre;
  logic [1:0] RegDst;
  logic       WrRegDSrc;
  logic       DBDataSrc;
  logic       ALUSrcB;
  logic       ExtSel;
  logic [2:0] ALUOp;
  logic [1:0] PCSrc;
  logic       mRD;
  logic       mWR;

  modport master (
    input  opcode, zero, sign,
    output state, PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc,
           DBDataSrc, ALUSrcB, ExtSel, ALUOp, PCSrc, mRD, mWR
  );

  modport slave (
    output opcode, zero, sign,
    input  state, PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc,
           DBDataSrc, ALUSrcB, ExtSel, ALUOp, PCSrc, mRD, mWR
  );
endinterface

// File: rtl/mc_op_decode.sv
// Purely combinational opcode classifier plus the opcode-only ALU controls.
module mc_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output opClass_t   opClass,
  output logic [2:0] aluOp,
  output logic       extSel,
  output logic       aluSrcB
);

  always_comb begin
    opClass = '0;
    aluOp   = ALU_ADD;
    extSel  = 1'b1;
    aluSrcB = 1'b0;
    case (opcode)
      OP_ADD:   opClass.isRtype = 1'b1;
      OP_SUB:   begin opClass.isRtype = 1'b1; aluOp = ALU_SUB; end
      OP_AND:   begin opClass.isRtype = 1'b1; aluOp = ALU_AND; end
      OP_SLT:   begin opClass.isRtype = 1'b1; aluOp = ALU_SLT; end
      OP_ADDIU: begin opClass.isImm = 1'b1; aluSrcB = 1'b1; end
      OP_ANDI:  begin opClass.isImm = 1'b1; aluSrcB = 1'b1; aluOp = ALU_AND; extSel = 1'b0; end
      OP_ORI:   begin opClass.isImm = 1'b1; aluSrcB = 1'b1; aluOp = ALU_OR;  extSel = 1'b0; end
      OP_SLTI:  begin opClass.isImm = 1'b1; aluSrcB = 1'b1; aluOp = ALU_SLT; end
      OP_LW:    begin opClass.isLoad = 1'b1;  aluSrcB = 1'b1; end
      OP_SW:    begin opClass.isStore = 1'b1; aluSrcB = 1'b1; end
      // bltz compares rs against $0, so the same subtract serves all branches
      OP_BEQ, OP_BNE, OP_BLTZ: begin opClass.isBranch = 1'b1; aluOp = ALU_SUB; end
      OP_J, OP_JR, OP_JAL:     opClass.isJump = 1'b1;
      OP_HALT:  opClass.isHalt = 1'b1;
      default:  opClass.isUndef = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Moore-style multi-cycle controller: IF/ID/EXE/MEM/WB sequencing with
// opcode-qualified enables; only PCSrc looks at the ALU zero/sign flags.
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
(
  input  logic          CLK,
  input  logic          Reset,
  mc_ctrl_unit_if.master bus
);

  logic [2:0] stateR;
  logic [2:0] stateNxt;
  opClass_t   opClass;
  logic [2:0] decAluOp;
  logic       decExtSel;
  logic       decAluSrcB;
  logic       branchTaken;
  logic       isArith;

  mc_op_decode uDecode (
    .opcode  (bus.opcode),
    .opClass (opClass),
    .aluOp   (decAluOp),
    .extSel  (decExtSel),
    .aluSrcB (decAluSrcB)
  );

  assign isArith     = opClass.isRtype | opClass.isImm;
  assign branchTaken = ((bus.opcode == OP_BEQ)  &  bus.zero) |
                       ((bus.opcode == OP_BNE)  & ~bus.zero) |
                       ((bus.opcode == OP_BLTZ) &  bus.sign);

  always_ff @(posedge CLK) begin
    if (Reset) stateR <= ST_IF;
    else       stateR <= stateNxt;
  end

  always_comb begin
    stateNxt = ST_IF;
    case (stateR)
      ST_IF:  stateNxt = ST_ID;
      ST_ID: begin
        if (opClass.isHalt)                            stateNxt = ST_HALT;
        else if (opClass.isJump || opClass.isUndef)    stateNxt = ST_IF;
        else                                           stateNxt = ST_EXE;
      end
      ST_EXE: begin
        if (opClass.isLoad || opClass.isStore) stateNxt = ST_MEM;
        else if (isArith)                      stateNxt = ST_WB_AL;
        else                                   stateNxt = ST_IF;
      end
      ST_MEM:  stateNxt = opClass.isLoad ? ST_WB_LD : ST_IF;
      ST_HALT: stateNxt = ST_HALT;
      default: stateNxt = ST_IF;
    endcase
  end

  // Output gating; Reset suppresses every write-type strobe.
  always_comb begin
    bus.state     = stateR;
    bus.InsMemRW  = (stateR == ST_IF);
    bus.PCWre     = 1'b0;
    bus.IRWre     = 1'b0;
    bus.RegWre    = 1'b0;
    bus.RegDst    = REGDST_RA;
    bus.WrRegDSrc = 1'b0;
    bus.DBDataSrc = 1'b0;
    bus.ALUSrcB   = 1'b0;
    bus.ExtSel    = 1'b0;
    bus.ALUOp     = ALU_ADD;
    bus.PCSrc     = PCSRC_SEQ;
    bus.mRD       = 1'b0;
    bus.mWR       = 1'b0;
    if (!Reset) begin
      bus.ALUSrcB = decAluSrcB;
      bus.ExtSel  = decExtSel;
      bus.ALUOp   = decAluOp;
      case (stateR)
        ST_IF: bus.IRWre = 1'b1;
        ST_ID: begin
          if (opClass.isJump || opClass.isUndef) begin
            bus.PCWre = 1'b1;
            if (bus.opcode == OP_JR)                         bus.PCSrc = PCSRC_REG;
            else if (bus.opcode == OP_J || bus.opcode == OP_JAL) bus.PCSrc = PCSRC_JUMP;
          end
          // jal links PC+4 into $31 during the same cycle the PC jumps
          if (bus.opcode == OP_JAL) bus.RegWre = 1'b1;
        end
        ST_EXE: begin
          if (opClass.isBranch) begin
            bus.PCWre = 1'b1;
            bus.PCSrc = branchTaken ? PCSRC_BRANCH : PCSRC_SEQ;
          end
        end
        ST_MEM: begin
          bus.mRD   = opClass.isLoad;
          bus.mWR   = opClass.isStore;
          bus.PCWre = opClass.isStore;
        end
        ST_WB_AL: begin
          bus.PCWre     = 1'b1;
          bus.RegWre    = 1'b1;
          bus.WrRegDSrc = 1'b1;
          bus.RegDst    = opClass.isRtype ? REGDST_RD : REGDST_RT;
        end
        ST_WB_LD: begin
          bus.PCWre     = 1'b1;
          bus.RegWre    = 1'b1;
          bus.WrRegDSrc = 1'b1;
          bus.DBDataSrc = 1'b1;
          bus.RegDst    = REGDST_RT;
          bus.mRD       = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit: stimulus queues hand-computed per-cycle
// output vectors, a negedge monitor pops and compares them.
module tb_mc_ctrl_unit;

  logic CLK;
  logic Reset;
  mc_ctrl_unit_if busIf ();

  mc_ctrl_unit dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (busIf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [5:0] ADD  = 6'b000000;
  localparam logic [5:0] ORI  = 6'b010010;
  localparam logic [5:0] SLT  = 6'b100110;
  localparam logic [5:0] SW   = 6'b110000;
  localparam logic [5:0] LW   = 6'b110001;
  localparam logic [5:0] BEQ  = 6'b110100;
  localparam logic [5:0] BNE  = 6'b110101;
  localparam logic [5:0] BLTZ = 6'b110110;
  localparam logic [5:0] J    = 6'b111000;
  localparam logic [5:0] JR   = 6'b111001;
  localparam logic [5:0] JAL  = 6'b111010;
  localparam logic [5:0] HALT = 6'b111111;
  localparam logic [5:0] UNDF = 6'b101010;

  // ALUSrcB, ExtSel, ALUOp bits; ignored where the cycle marks them don't-care
  localparam logic [19:0] ALU_MASK = 20'h001F0;

  logic [19:0] expQ[$];
  logic        careQ[$];
  string       nameQ[$];
  int          checks = 0;
  int          errors = 0;

  // Field order: state, {PCWre,IRWre,InsMemRW,RegWre}, RegDst,
  // {WrRegDSrc,DBDataSrc,ALUSrcB,ExtSel}, ALUOp, PCSrc, {mRD,mWR}
  function automatic logic [19:0] mk(input logic [2:0] st, input logic [3:0] en,
                                     input logic [1:0] rd, input logic [3:0] src,
                                     input logic [2:0] aop, input logic [1:0] pcs,
                                     input logic [1:0] mem);
    return {st, en, rd, src, aop, pcs, mem};
  endfunction

  task automatic cyc(input logic rst, input logic [5:0] op, input logic z,
                     input logic s, input logic [19:0] e, input logic care,
                     input string name);
    Reset         = rst;
    busIf.opcode  = op;
    busIf.zero    = z;
    busIf.sign    = s;
    expQ.push_back(e);
    careQ.push_back(care);
    nameQ.push_back(name);
    @(posedge CLK);
    #1;
  endtask

  task automatic fetchDecode(input logic [5:0] op, input string name);
    cyc(1'b0, op, 1'b0, 1'b0, mk(3'd0, 4'b0110, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00), 1'b0, {name, "_IF"});
    cyc(1'b0, op, 1'b0, 1'b0, mk(3'd1, 4'b0000, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00), 1'b0, {name, "_ID"});
  endtask

  always @(negedge CLK) begin
    if (expQ.size() > 0) begin
      logic [19:0] e;
      logic [19:0] act;
      logic        care;
      string       nm;
      e    = expQ.pop_front();
      care = careQ.pop_front();
      nm   = nameQ.pop_front();
      act  = {busIf.state, busIf.PCWre, busIf.IRWre, busIf.InsMemRW, busIf.RegWre,
              busIf.RegDst, busIf.WrRegDSrc, busIf.DBDataSrc, busIf.ALUSrcB,
              busIf.ExtSel, busIf.ALUOp, busIf.PCSrc, busIf.mRD, busIf.mWR};
      if (!care) begin
        act = act & ~ALU_MASK;
        e   = e   & ~ALU_MASK;
      end
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: actual=%b required=%b", nm, act, e);
      end
    end
  end

  initial begin
    Reset        = 1'b1;
    busIf.opcode = ADD;
    busIf.zero   = 1'b0;
    busIf.sign   = 1'b0;
    @(posedge CLK);
    #1;

    // Reset held: only state and InsMemRW visible, decode outputs forced low
    cyc(1'b1, ADD, 1'b0, 1'b0, mk(3'd0, 4'b0010, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00), 1'b1, "reset_IF");

    fetchDecode(ADD, "add");
    cyc(1'b0, ADD, 1'b1, 1'b0, mk(3'd2, 4'b0000, 2'b00, 4'b0001, 3'b000, 2'b00, 2'b00), 1'b1, "add_EXE");
    cyc(1'b0, ADD, 1'b1, 1'b1, mk(3'd4, 4'b1001, 2'b10, 4'b1001, 3'b000, 2'b00, 2'b00), 1'b1, "add_WB");

    fetchDecode(LW, "lw");
    cyc(1'b0, LW, 1'b0, 1'b0, mk(3'd2, 4'b0000, 2'b00, 4'b0011, 3'b000, 2'b00, 2'b00), 1'b1, "lw_EXE");
    cyc(1'b0, LW, 1'b0, 1'b0, mk(3'd3, 4'b0000, 2'b00, 4'b0011, 3'b000, 2'b00, 2'b10), 1'b1, "lw_MEM");
    cyc(1'b0, LW, 1'b0, 1'b0, mk(3'd5, 4'b1001, 2'b01, 4'b1111, 3'b000, 2'b00, 2'b10), 1'b1, "lw_WB");

    fetchDecode(BEQ, "beqT");
    cyc(1'b0, BEQ, 1'b1, 1'b0, mk(3'd2, 4'b1000, 2'b00, 4'b0001, 3'b001, 2'b01, 2'b00), 1'b1, "beqT_EXE");
    fetchDecode(BEQ, "beqN");
    cyc(1'b0, BEQ, 1'b0, 1'b0, mk(3'd2, 4'b1000, 2'b00, 4'b0001, 3'b001, 2'b00, 2'b00), 1'b1, "beqN_EXE");
    fetchDecode(BNE, "bneT");
    cyc(1'b0, BNE, 1'b0, 1'b0, mk(3'd2, 4'b1000, 2'b00, 4'b0001, 3'b001, 2'b01, 2'b00), 1'b1, "bneT_EXE");
    fetchDecode(BLTZ, "bltzT");
    cyc(1'b0, BLTZ, 1'b0, 1'b1, mk(3'd2, 4'b1000, 2'b00, 4'b0001, 3'b001, 2'b01, 2'b00), 1'b1, "bltzT_EXE");
    fetchDecode(BLTZ, "bltzN");
    cyc(1'b0, BLTZ, 1'b1, 1'b0, mk(3'd2, 4'b1000, 2'b00, 4'b0001, 3'b001, 2'b00, 2'b00), 1'b1, "bltzN_EXE");

    cyc(1'b0, JAL, 1'b0, 1'b0, mk(3'd0, 4'b0110, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00), 1'b0, "jal_IF");
    cyc(1'b0, JAL, 1'b0, 1'b0, mk(3'd1, 4'b1001, 2'b00, 4'b0000, 3'b000, 2'b11, 2'b00), 1'b0, "jal_ID");
    cyc(1'b0, J, 1'b0, 1'b0, mk(3'd0, 4'b0110, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00), 1'b0, "j_IF");
    cyc(1'b0, J, 1'b0, 1'b0, mk(3'd1, 4'b1000, 2'b00, 4'b0000, 3'b000, 2'b11, 2'b00), 1'b0, "j_ID");
    cyc(1'b0, JR, 1'b0, 1'b0, mk(3'd0, 4'b0110, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00), 1'b0, "jr_IF");
    cyc(1'b0, JR, 1'b0, 1'b0, mk(3'd1, 4'b1000, 2'b00, 4'b0000, 3'b000, 2'b10, 2'b00), 1'b0, "jr_ID");
    cyc(1'b0, UNDF, 1'b1, 1'b1, mk(3'd0, 4'b0110, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00), 1'b0, "undef_IF");
    cyc(1'b0, UNDF, 1'b1, 1'b1, mk(3'd1, 4'b1000, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00), 1'b0, "undef_ID");

    fetchDecode(ORI, "ori");
    cyc(1'b0, ORI, 1'b0, 1'b0, mk(3'd2, 4'b0000, 2'b00, 4'b0010, 3'b100, 2'b00, 2'b00), 1'b1, "ori_EXE");
    cyc(1'b0, ORI, 1'b0, 1'b0, mk(3'd4, 4'b1001, 2'b01, 4'b1010, 3'b100, 2'b00, 2'b00), 1'b1, "ori_WB");
    fetchDecode(SLT, "slt");
    cyc(1'b0, SLT, 1'b0, 1'b1, mk(3'd2, 4'b0000, 2'b00, 4'b0001, 3'b010, 2'b00, 2'b00), 1'b1, "slt_EXE");
    cyc(1'b0, SLT, 1'b0, 1'b1, mk(3'd4, 4'b1001, 2'b10, 4'b1001, 3'b010, 2'b00, 2'b00), 1'b1, "slt_WB");

    fetchDecode(SW, "sw");
    cyc(1'b0, SW, 1'b0, 1'b0, mk(3'd2, 4'b0000, 2'b00, 4'b0011, 3'b000, 2'b00, 2'b00), 1'b1, "sw_EXE");
    cyc(1'b0, SW, 1'b0, 1'b0, mk(3'd3, 4'b1000, 2'b00, 4'b0011, 3'b000, 2'b00, 2'b01), 1'b1, "sw_MEM");

    // Second store is abandoned by Reset in MEM: no mWR, back to IF
    fetchDecode(SW, "swRst");
    cyc(1'b0, SW, 1'b0, 1'b0, mk(3'd2, 4'b0000, 2'b00, 4'b0011, 3'b000, 2'b00, 2'b00), 1'b1, "swRst_EXE");
    cyc(1'b1, SW, 1'b0, 1'b0, mk(3'd3, 4'b0000, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00), 1'b1, "swRst_MEM");

    fetchDecode(HALT, "halt");
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, HALT, i[0], i[1], mk(3'd7, 4'b0000, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00), 1'b0, "halt_hold");
    end
    cyc(1'b1, HALT, 1'b0, 1'b0, mk(3'd7, 4'b0000, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00), 1'b1, "halt_rst");
    cyc(1'b0, ADD, 1'b0, 1'b0, mk(3'd0, 4'b0110, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00), 1'b0, "post_halt_IF");
    cyc(1'b0, ADD, 1'b0, 1'b0, mk(3'd1, 4'b0000, 2'b00, 4'b0000, 3'b000, 2'b00, 2'b00), 1'b0, "post_halt_ID");

    @(posedge CLK);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending required=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
